// File: rtl/wbu_commit_stage_if.sv
// LSU -> write-back bundle: one retiring instruction offered under m_valid/w_ready.
// Handshake: a transfer happens on a rising clk edge where m_valid && w_ready; the
// master holds every payload field stable while m_valid is high and w_ready is low.
interface wbu_commit_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int RADDR_W    = 5
);
  logic                  m_valid;
  logic                  w_ready;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [DATA_WIDTH-1:0] read_data;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] csr_rdata;
  logic [1:0]            res_src;
  logic [2:0]            load_op;
  logic [RADDR_W-1:0]    rd;
  logic                  reg_write;

  modport master (
    output m_valid, alu_result, read_data, pc, csr_rdata, res_src, load_op, rd, reg_write,
    input  w_ready
  );

  modport slave (
    input  m_valid, alu_result, read_data, pc, csr_rdata, res_src, load_op, rd, reg_write,
    output w_ready
  );
endinterface

// File: rtl/wbu_commit_stage.sv
// Write-back/commit stage: load align/extend, result select, integer regfile with
// write-through read ports, and a one-cycle commit pulse per retired instruction.
module wbu_commit_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int RADDR_W    = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  wbu_commit_stage_if.slave     lsu,
  input  logic [RADDR_W-1:0]    rs1,
  input  logic [RADDR_W-1:0]    rs2,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  commit_valid,
  output logic [DATA_WIDTH-1:0] commit_pc,
  output logic                  load_err,
  output logic                  dbg_state_o
);

  localparam int NREG = 2 ** RADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t                state_q;
  logic                  w_ready_q;
  logic                  commit_valid_q;
  logic [DATA_WIDTH-1:0] commit_pc_q;
  logic                  load_err_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [RADDR_W-1:0]    rd_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] rf_q [NREG];

  logic [1:0]            off;
  logic [DATA_WIDTH-1:0] byte_sh;
  logic [DATA_WIDTH-1:0] half_sh;
  logic [DATA_WIDTH-1:0] load_val;
  logic                  ld_bad;
  logic                  load_err_d;
  logic [DATA_WIDTH-1:0] result_d;
  logic                  we_d;

  assign off     = lsu.alu_result[1:0];
  assign byte_sh = lsu.read_data >> {off, 3'b000};
  assign half_sh = lsu.read_data >> {off[1], 4'b0000};

  always_comb begin
    load_val = lsu.read_data;
    ld_bad   = 1'b0;
    case (lsu.load_op)
      3'd0: load_val = {{(DATA_WIDTH-8){byte_sh[7]}}, byte_sh[7:0]};
      3'd4: load_val = {{(DATA_WIDTH-8){1'b0}}, byte_sh[7:0]};
      3'd1: begin
        load_val = {{(DATA_WIDTH-16){half_sh[15]}}, half_sh[15:0]};
        ld_bad   = off[0];
      end
      3'd5: begin
        load_val = {{(DATA_WIDTH-16){1'b0}}, half_sh[15:0]};
        ld_bad   = off[0];
      end
      3'd2:    ld_bad = |off;
      default: ld_bad = 1'b1;
    endcase
  end

  // A bad load_op/alignment only matters when the memory result is the one retired.
  assign load_err_d = (lsu.res_src == 2'd1) && ld_bad;
  assign we_d       = lsu.reg_write && (lsu.rd != '0) && !load_err_d;

  always_comb begin
    result_d = lsu.alu_result;
    case (lsu.res_src)
      2'd1:    result_d = load_val;
      2'd2:    result_d = lsu.pc + DATA_WIDTH'(4);
      2'd3:    result_d = lsu.csr_rdata;
      default: result_d = lsu.alu_result;
    endcase
  end

  // The one-entry buffer holds the already-resolved write, so WRITE only commits it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= IDLE;
      w_ready_q      <= 1'b1;
      commit_valid_q <= 1'b0;
      commit_pc_q    <= '0;
      load_err_q     <= 1'b0;
      wdata_q        <= '0;
      rd_q           <= '0;
      we_q           <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          commit_valid_q <= 1'b0;
          load_err_q     <= 1'b0;
          if (lsu.m_valid && w_ready_q) begin
            state_q        <= WRITE;
            w_ready_q      <= 1'b0;
            commit_valid_q <= 1'b1;
            commit_pc_q    <= lsu.pc;
            load_err_q     <= load_err_d;
            wdata_q        <= result_d;
            rd_q           <= lsu.rd;
            we_q           <= we_d;
          end
        end
        WRITE: begin
          if (we_q) rf_q[rd_q] <= wdata_q;
          state_q        <= IDLE;
          w_ready_q      <= 1'b1;
          commit_valid_q <= 1'b0;
          load_err_q     <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          w_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // A reset arriving during WRITE cancels the retire, so the pulse is masked at once.
  assign commit_valid = commit_valid_q & rstn;
  assign load_err     = load_err_q & rstn;
  assign commit_pc    = commit_pc_q;
  assign lsu.w_ready  = w_ready_q;
  assign dbg_state_o  = (state_q == WRITE);

  always_comb begin
    rs1_data = rf_q[rs1];
    if (rs1 == '0)
      rs1_data = '0;
    else if ((state_q == WRITE) && we_q && (rs1 == rd_q))
      rs1_data = wdata_q;
  end

  always_comb begin
    rs2_data = rf_q[rs2];
    if (rs2 == '0)
      rs2_data = '0;
    else if ((state_q == WRITE) && we_q && (rs2 == rd_q))
      rs2_data = wdata_q;
  end

endmodule
